morse_rx_ctrl: RTL and testbench

Receive-side sequencer for the Morse symbol decoder.
- Samples a raw on/off key line once per Morse time unit and assembles each character's unit pattern.
- Detects character and word gaps and presents the finished pattern to the decoder's 24-bit `x` input.
- Captures the decoder's 8-bit ASCII result and queues it in a small output FIFO with a valid/ready interface.
- Sits between the key input pin and the UART/display consumer; the decoder itself is unchanged.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_char_fifo.sv | 50 +++++
 rtl/morse_rx_ctrl.sv | 172 +++++++++++++++++
 tb/tb_morse_rx_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive sequencer.
// Holds the FSM state encoding, error codes, pattern width and the ASCII
// values the external decoder uses for word space and end of work.
package morse_pkg;

  localparam int unsigned MORSE_W = 24;
  localparam int unsigned CHAR_W  = 8;

  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] ASCII_EOW   = 8'hFF;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BADCODE = 2'b01,
    ERR_OVF     = 2'b10,
    ERR_LONG    = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StDiscard,
    StLoad,
    StWait,
    StCapture,
    StGap
  } state_e;

endpackage

// File: rtl/morse_char_fifo.sv
// Character queue between the sequencer and the consumer.
// Ports:
//   clk, en    - clock and asynchronous active-low reset
//   push/wdata - write side; a push while full is accepted only with a pop
//   pop/rdata  - read side; rdata is the head entry, 0 when empty
//   full/empty - occupancy flags from registered pointers
module morse_char_fifo
  import morse_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [CHAR_W-1:0] wdata,
  output logic [CHAR_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: rdata is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/morse_rx_ctrl.sv
// Receive-side sequencer for the Morse symbol decoder.
// Samples the key line mid-unit, assembles each character's unit pattern,
// hands it to the external decoder and queues the ASCII result.
// Ports:
//   clk, en          - clock and asynchronous active-low reset (also decoder reset)
//   key_i            - raw asynchronous key line, 1 = tone
//   dec_en_o         - decoder reset, equals en
//   dec_x_o, dec_y_i - pattern to / result from the decoder
//   char_o, valid_o, ready_i - output queue head, valid/ready handshake
//   err_o            - one-cycle error pulse (err_e)
module morse_rx_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               en,
  input  logic               key_i,
  output logic               dec_en_o,
  output logic [MORSE_W-1:0] dec_x_o,
  input  logic [CHAR_W-1:0]  dec_y_i,
  output logic [CHAR_W-1:0]  char_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         err_o
);

  localparam int unsigned   CntW   = $clog2(UNIT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(UNIT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMid = CntW'(UNIT_CYCLES / 2);
  localparam logic [4:0]    LenMax = 5'(MORSE_W);

  logic               key_meta_q, key_s_q, key_prev_q, key_rise;
  logic [CntW-1:0]    cnt_q;
  logic               tick;
  logic [MORSE_W-1:0] sh_q, code_q, dec_x_q;
  logic [4:0]         len_q;
  logic [2:0]         zr_q, zr_next;
  state_e             state_q, state_d;
  err_e               err_d, err_q;
  logic               push, pop, full, empty;

  assign key_rise = key_s_q & ~key_prev_q;
  assign tick     = (cnt_q == CntMid);
  assign zr_next  = key_s_q ? 3'd0 : ((zr_q == 3'd7) ? 3'd7 : zr_q + 3'd1);

  assign dec_en_o = en;
  assign dec_x_o  = dec_x_q;
  assign err_o    = err_q;
  assign valid_o  = ~empty;
  assign pop      = valid_o & ready_i;

  // State register
  always_ff @(posedge clk or negedge en) begin
    if (!en) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (key_rise) state_d = StCollect;
      StCollect: begin
        if (zr_q == 3'd3)         state_d = StLoad;
        else if (len_q == LenMax) state_d = StDiscard;
      end
      StDiscard: if (zr_q == 3'd3) state_d = StIdle;
      StLoad:    state_d = StWait;
      StWait:    state_d = StCapture;
      // Only a successfully decoded character arms the word-space gap.
      StCapture: state_d = ((code_q != '0) && (dec_y_i != '0)) ? StGap : StIdle;
      StGap: begin
        if (key_rise)          state_d = StCollect;
        else if (zr_q == 3'd7) state_d = StLoad;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Outputs: queue push and error classification
  always_comb begin
    push  = 1'b0;
    err_d = ERR_NONE;
    unique case (state_q)
      StCollect: if (zr_q != 3'd3 && len_q == LenMax) err_d = ERR_LONG;
      StCapture: begin
        if (dec_y_i == '0 && code_q != '0) err_d = ERR_BADCODE;
        else if (full && !pop)             err_d = ERR_OVF;  // pop frees a slot first
        else                               push  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      key_prev_q <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
      len_q      <= '0;
      zr_q       <= '0;
      code_q     <= '0;
      dec_x_q    <= '0;
      err_q      <= ERR_NONE;
    end else begin
      key_meta_q <= key_i;
      key_s_q    <= key_meta_q;
      key_prev_q <= key_s_q;
      err_q      <= err_d;

      // Realign the unit grid to the first tone edge of a character.
      if (key_rise && (state_q == StIdle || state_q == StGap)) cnt_q <= '0;
      else if (cnt_q == CntMax)                                cnt_q <= '0;
      else                                                     cnt_q <= cnt_q + CntW'(1);

      unique case (state_q)
        StIdle: begin
          sh_q  <= '0;
          len_q <= '0;
          zr_q  <= '0;
        end
        StCollect, StDiscard: begin
          if (tick) begin
            sh_q  <= {sh_q[MORSE_W-2:0], key_s_q};
            len_q <= len_q + 5'd1;
            zr_q  <= zr_next;
          end
        end
        StCapture: begin
          if (state_d == StGap) begin
            sh_q  <= '0;
            len_q <= '0;
          end
        end
        StGap: begin
          if (key_rise) begin
            sh_q  <= '0;
            len_q <= '0;
            zr_q  <= '0;
          end else if (tick) begin
            zr_q <= zr_next;
          end
        end
        default: ;
      endcase

      // sh>>2 drops two of the three trailing zeros; the gap path sends word space.
      if (state_q == StCollect && state_d == StLoad) code_q <= sh_q >> 2;
      else if (state_q == StGap && state_d == StLoad) code_q <= '0;

      if (state_q == StLoad) dec_x_q <= code_q;
    end
  end

  morse_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .en    (en),
    .push  (push),
    .pop   (pop),
    .wdata (dec_y_i),
    .rdata (char_o),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_morse_rx_ctrl.sv
module tb_morse_rx_ctrl;

  localparam int unsigned U = 8;

  logic        clk     = 1'b0;
  logic        en      = 1'b1;
  logic        key_i   = 1'b0;
  logic        ready_i = 1'b1;
  logic        dec_en_o;
  logic [23:0] dec_x_o;
  logic [7:0]  dec_y_i;
  logic [7:0]  char_o;
  logic        valid_o;
  logic [1:0]  err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_chars [$];
  logic [1:0] exp_errs  [$];

  always #5 clk = ~clk;

  morse_rx_ctrl #(
    .UNIT_CYCLES (U),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .en       (en),
    .key_i    (key_i),
    .dec_en_o (dec_en_o),
    .dec_x_o  (dec_x_o),
    .dec_y_i  (dec_y_i),
    .char_o   (char_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .err_o    (err_o)
  );

  // Decoder model: registered table lookup, cleared by dec_en_o.
  function automatic logic [7:0] lookup(input logic [23:0] x);
    case (x)
      24'b010:     return 8'h45;
      24'b0101110: return 8'h41;
      24'b01110:   return 8'h54;
      24'b0:       return 8'h20;
      default:     return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge dec_en_o) begin
    if (!dec_en_o) dec_y_i <= 8'h00;
    else           dec_y_i <= lookup(dec_x_o);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key_for(input logic v, input int units);
    key_i = v;
    cyc(units * U);
  endtask

  // Units MSB first, then three off units and a few cycles for the lookup.
  task automatic send_char(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) key_for(bits[i], 1);
    key_for(1'b0, 3);
    cyc(4);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (en === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_chars.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL char_unexpected: got %0h expected none", char_o);
      end else begin
        check("char", {24'h0, char_o}, {24'h0, exp_chars.pop_front()});
      end
    end
    if (en === 1'b1 && err_o !== 2'b00) begin
      if (exp_errs.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL err_unexpected: got %0h expected none", err_o);
      end else begin
        check("err", {30'h0, err_o}, {30'h0, exp_errs.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 en = 1'b0;
    cyc(3);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_dec_x", {8'h0, dec_x_o}, 32'h0);
    check("rst_char", {24'h0, char_o}, 32'h0);
    check("rst_err", {30'h0, err_o}, 32'h0);
    check("rst_dec_en", {31'h0, dec_en_o}, 32'h0);
    en = 1'b1;
    cyc(2);
    check("dec_en", {31'h0, dec_en_o}, 32'h1);

    // E then A within a word
    exp_chars.push_back(8'h45);
    send_char(32'b1, 1);
    check("e_dec_x", {8'h0, dec_x_o}, 32'b010);
    exp_chars.push_back(8'h41);
    send_char(32'b10111, 5);
    check("a_dec_x", {8'h0, dec_x_o}, 32'b0101110);

    // Word space once, then idle emits nothing more
    exp_chars.push_back(8'h20);
    key_for(1'b0, 5);
    check("ws_dec_x", {8'h0, dec_x_o}, 32'h0);
    key_for(1'b0, 7);
    exp_chars.push_back(8'h45);
    send_char(32'b1, 1);
    exp_chars.push_back(8'h20);
    key_for(1'b0, 5);

    // Undefined pattern: error, no push, no word space
    exp_errs.push_back(2'b01);
    send_char(32'b1111, 4);
    check("bad_dec_x", {8'h0, dec_x_o}, 32'b011110);
    key_for(1'b0, 8);

    // Over-long symbol discarded, next character fine
    exp_errs.push_back(2'b11);
    key_for(1'b1, 25);
    key_for(1'b0, 4);
    exp_chars.push_back(8'h45);
    send_char(32'b1, 1);
    exp_chars.push_back(8'h20);
    key_for(1'b0, 5);

    // Overflow with consumer stalled
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_chars.push_back(8'h45);
      send_char(32'b1, 1);
    end
    exp_errs.push_back(2'b10);
    send_char(32'b1, 1);
    check("ovf_valid", {31'h0, valid_o}, 32'h1);
    check("ovf_char", {24'h0, char_o}, 32'h45);
    ready_i = 1'b1;
    cyc(6);
    check("ovf_drained", exp_chars.size(), 32'h0);
    exp_chars.push_back(8'h20);
    key_for(1'b0, 5);

    // Reset mid-pattern after two dots
    key_for(1'b1, 1);
    key_for(1'b0, 1);
    key_for(1'b1, 1);
    key_for(1'b0, 1);
    en = 1'b0;
    #2;
    check("mid_rst_valid", {31'h0, valid_o}, 32'h0);
    check("mid_rst_dec_x", {8'h0, dec_x_o}, 32'h0);
    check("mid_rst_char", {24'h0, char_o}, 32'h0);
    check("mid_rst_err", {30'h0, err_o}, 32'h0);
    cyc(3);
    en = 1'b1;
    cyc(2);
    exp_chars.push_back(8'h54);
    send_char(32'b111, 3);
    check("t_dec_x", {8'h0, dec_x_o}, 32'b01110);
    exp_chars.push_back(8'h20);
    key_for(1'b0, 5);

    check("chars_left", exp_chars.size(), 32'h0);
    check("errs_left", exp_errs.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
